// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - LSB-first word serializer with per-bit hold, abort and done pulse
// Optional build macro SEQ_SERIALIZER_PARITY_EN appends one even-parity bit after the data bits.
module seq_serializer #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [7:0]    LAST_HOLD = 8'(BIT_CYCLES - 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
  logic parity;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic [7:0]       hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      load_ready <= 1'b1;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort is deliberately not consulted here: a load offered alongside it is accepted
          if (load_valid) begin
            state      <= SHIFT;
            sreg       <= load_data;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            load_ready <= 1'b0;
            ser_out    <= load_data[0];
            ser_valid  <= 1'b1;
            busy       <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity     <= ^load_data;
`endif
          end
        end

        SHIFT: begin
          if (abort) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            load_ready <= 1'b1;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
          end else if (hold_cnt != LAST_HOLD) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else begin
            hold_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
              state   <= PARITY;
              ser_out <= parity;
`else
              state     <= DONE;
              done      <= 1'b1;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              busy      <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              sreg    <= sreg >> 1;
              ser_out <= sreg[1];
            end
          end
        end

`ifdef SEQ_SERIALIZER_PARITY_EN
        PARITY: begin
          if (abort) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            load_ready <= 1'b1;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            busy       <= 1'b0;
          end else if (hold_cnt != LAST_HOLD) begin
            hold_cnt <= hold_cnt + 8'd1;
          end else begin
            hold_cnt  <= '0;
            state     <= DONE;
            done      <= 1'b1;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
`endif

        DONE: begin
          state      <= IDLE;
          load_ready <= 1'b1;
        end

        default: begin
          state      <= IDLE;
          load_ready <= 1'b1;
          ser_out    <= 1'b0;
          ser_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
